// File: rtl/adder_pkg.sv
// Shared definitions for the adder slice: default operand width and the
// registered status-flag bundle.
package adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/adder_if.sv
// Operand/result bundle between the adder and its user. `master` drives the
// operands, and `slave` is the adder side.
interface adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  // Handshake: in_valid=1 at a rising clk edge captures a/b. out_valid is
  // in_valid delayed by one cycle. There is no ready, so a capture is never
  // refused. Reset is the only thing that can stop a capture from happening.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic             out_valid;

  modport master (
    output a, b, in_valid,
    input  out, sum_q, carry_q, ovf_q, zero_q, neg_q, out_valid
  );

  modport slave (
    input  a, b, in_valid,
    output out, sum_q, carry_q, ovf_q, zero_q, neg_q, out_valid
  );

endinterface

// File: rtl/adder_flags.sv
// Combinational status flags for a WIDTH-bit sum. The inputs are the sum,
// its carry-out and the MSBs of the two operands.
module adder_flags
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  output flags_t           flags_o
);

  always_comb begin
    flags_o       = '0;
    flags_o.carry = carry_i;
    // Signed overflow: the operands agree in sign and the result does not.
    flags_o.ovf   = (a_msb_i == b_msb_i) && (sum_i[WIDTH-1] != a_msb_i);
    flags_o.zero  = (sum_i == '0);
    flags_o.neg   = sum_i[WIDTH-1];
  end

endmodule

// File: rtl/adder.sv
// WIDTH-bit adder with a combinational sum and a registered sum/flag path.
// Define ADDER_FLAGS_EN to compute carry/ovf/zero/neg; otherwise they read 0.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic    clk,
  input logic    rst,
  adder_if.slave bus
);

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             valid_d, valid_q;
  flags_t           flags;

  assign sum_full = {1'b0, bus.a} + {1'b0, bus.b};
  assign bus.out  = sum_full[WIDTH-1:0];

  // An if-test (not a mux) so an undriven in_valid falls to "no capture".
  always_comb begin
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = sum_full[WIDTH-1:0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

`ifdef ADDER_FLAGS_EN
  flags_t flags_calc, flags_d, flags_q;

  adder_flags #(.WIDTH(WIDTH)) u_flags (
    .sum_i   (sum_full[WIDTH-1:0]),
    .carry_i (sum_full[WIDTH]),
    .a_msb_i (bus.a[WIDTH-1]),
    .b_msb_i (bus.b[WIDTH-1]),
    .flags_o (flags_calc)
  );

  always_comb begin
    flags_d = flags_q;
    if (bus.in_valid) flags_d = flags_calc;
  end

  // The cleared sum is zero, so zero_q comes out of reset set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '{carry: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = sum_full[WIDTH];
  assign flags        = '0;
`endif

  assign bus.sum_q     = sum_q;
  assign bus.out_valid = valid_q;
  assign bus.carry_q   = flags.carry;
  assign bus.ovf_q     = flags.ovf;
  assign bus.zero_q    = flags.zero;
  assign bus.neg_q     = flags.neg;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed and random operands checked against an
// integer-arithmetic reference model.
module tb_adder;
  import adder_pkg::*;

  localparam int W = WIDTH_DEF;
`ifdef ADDER_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_if #(.WIDTH(W)) bus ();

  adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  // Each entry is {sum, carry, ovf, zero, neg}.
  logic [W+3:0] exp_q[$];
  logic [W+3:0] held;
  logic [W+3:0] reset_val;

  // The reference model uses integer arithmetic on unsigned and signed values.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ua, ub, u;
    int sa, sb, ss;
    logic [W-1:0] s;
    logic c, o, z, n;
    ua = int'(a);
    ub = int'(b);
    u  = ua + ub;
    s  = W'(u % (1 << W));
    c  = (u >= (1 << W));
    sa = (ua >= (1 << (W-1))) ? int'(ua) - (1 << W) : int'(ua);
    sb = (ub >= (1 << (W-1))) ? int'(ub) - (1 << W) : int'(ub);
    ss = sa + sb;
    o  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    z  = (u % (1 << W)) == 0;
    n  = (u % (1 << W)) >= (1 << (W-1));
    return {s, c & FLAGS_ON, o & FLAGS_ON, z & FLAGS_ON, n & FLAGS_ON};
  endfunction

  function automatic logic [W+4:0] observed();
    return {bus.sum_q, bus.carry_q, bus.ovf_q, bus.zero_q, bus.neg_q, bus.out_valid};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.a = W'(3);
    bus.b = W'(4);
    #1 rst = 1'b1;
    #6;
    checks++;
    if (observed() !== {reset_val, 1'b0}) begin
      failures++;
      $display("FAIL reset_regs got=%h exp=%h", observed(), {reset_val, 1'b0});
    end
    checks++;
    if (bus.out !== W'(7)) begin
      failures++;
      $display("FAIL out_during_reset got=%h exp=%h", bus.out, W'(7));
    end
    @(negedge clk);
    rst  = 1'b0;
    held = reset_val;
  endtask

  task automatic test_comb();
    logic [W-1:0] va [4] = '{W'(0), W'(1), W'(1), W'(20)};
    logic [W-1:0] vb [4] = '{W'(0), W'(0), W'(1), W'(6)};
    logic [W-1:0] vo [4] = '{W'(0), W'(1), W'(2), W'(26)};
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      bus.a = va[i];
      bus.b = vb[i];
      #10;
      checks++;
      if (bus.out !== vo[i]) begin
        failures++;
        $display("FAIL comb_directed[%0d] got=%h exp=%h", i, bus.out, vo[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      bus.a = W'($urandom_range(0, (1 << W) - 1));
      bus.b = W'($urandom_range(0, (1 << W) - 1));
      #3;
      e = model(bus.a, bus.b) >> 4;
      checks++;
      if (bus.out !== e) begin
        failures++;
        $display("FAIL comb_random a=%h b=%h got=%h exp=%h", bus.a, bus.b, bus.out, e);
      end
    end
  endtask

  task automatic test_capture(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    logic [W+3:0] e;
    e = model(a, b);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.out !== e[W+3:4]) begin
      failures++;
      $display("FAIL %s_out got=%h exp=%h", name, bus.out, e[W+3:4]);
    end
    @(posedge clk);
    #1;
    held = e;
    checks++;
    if (observed() !== {e, 1'b1}) begin
      failures++;
      $display("FAIL %s_capture got=%h exp=%h", name, observed(), {e, 1'b1});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom_range(0, (1 << W) - 1));
    bus.b = W'($urandom_range(0, (1 << W) - 1));
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {held, 1'b0}) begin
      failures++;
      $display("FAIL %s_hold got=%h exp=%h", name, observed(), {held, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic v;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.a = W'($urandom_range(0, (1 << W) - 1));
      bus.b = W'($urandom_range(0, (1 << W) - 1));
      v = (i < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.in_valid = v;
      if (v) exp_q.push_back(model(bus.a, bus.b));
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== v) begin
        failures++;
        $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, bus.out_valid, v);
      end
      if (v && exp_q.size() > 0) held = exp_q.pop_front();
      checks++;
      if (observed() >> 1 !== {1'b0, held}) begin
        failures++;
        $display("FAIL b2b_regs[%0d] got=%h exp=%h", i, observed() >> 1, held);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.a = W'(8'h11);
    bus.b = W'(8'h22);
    bus.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (observed() !== {reset_val, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_async got=%h exp=%h", observed(), {reset_val, 1'b0});
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {reset_val, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_edge got=%h exp=%h", observed(), {reset_val, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.a = W'(5);
    bus.b = W'(6);
    #1;
    checks++;
    if (observed() !== {reset_val, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_release got=%h exp=%h", observed(), {reset_val, 1'b0});
    end
    @(posedge clk);
    #1;
    held = model(W'(5), W'(6));
    checks++;
    if (observed() !== {held, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_first_capture got=%h exp=%h", observed(), {held, 1'b1});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_val = {W'(0), 1'b0, 1'b0, FLAGS_ON, 1'b0};
    bus.a = '0;
    bus.b = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_comb();
    test_capture(W'(8'h0A), W'(8'hFD), "pos_plus_neg");
    test_capture(W'(8'h02), W'(8'hFB), "neg_result");
    test_capture(W'(8'h7F), W'(8'h01), "pos_ovf");
    test_capture(W'(8'h80), W'(8'h80), "neg_ovf_zero");
    test_capture(W'(8'h00), W'(8'h00), "zero");
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 clk  input  1  single clock; all registered state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  WIDTH  operand A, two's-complement or unsigned.
REQ-005 b  input  WIDTH  operand B, two's-complement or unsigned.
REQ-006 out  output  WIDTH  combinational sum, (a + b) mod 2^WIDTH.
REQ-007 in_valid  input  1  capture request for registered path; an undriven or low input means no capture.
REQ-008 sum_q  output  WIDTH  registered sum.
REQ-009 carry_q  output  1  registered unsigned carry-out.
REQ-010 ovf_q  output  1  registered signed overflow.
REQ-011 zero_q  output  1  registered sum == 0.
REQ-012 neg_q  output  1  registered sum MSB.
REQ-013 out_valid  output  1  registered sum/flags valid strobe.

Function
REQ-014 out SHALL be purely combinational, with zero-cycle latency from a/b, and SHALL not depend on clk, rst or in_valid.
REQ-015 Sum SHALL be computed at WIDTH+1 bits: carry = bit WIDTH; result = low WIDTH bits, wrapping modulo 2^WIDTH.
REQ-016 Signed overflow SHALL be 1 iff a and b have equal MSBs and the result MSB differs from them.
REQ-017 On a rising clk edge with in_valid=1, sum_q, carry_q, ovf_q, zero_q and neg_q SHALL load the values for the current a/b; latency is 1 cycle.
REQ-018 out_valid SHALL equal in_valid delayed one cycle, giving a 1-cycle pulse per capture; back-to-back captures SHALL keep it high.
REQ-019 With in_valid=0, registered outputs SHALL hold their values and out_valid SHALL be 0.
REQ-020 Negation convention: -x = (~x + 1) mod 2^WIDTH; -0 = 0; the most-negative value negates to itself.

Reset
REQ-021 rst=1 SHALL immediately clear sum_q, carry_q, ovf_q, neg_q and out_valid to 0, and SHALL set zero_q to 1, without waiting for clk.
REQ-022 Reset asserted mid-capture SHALL win over in_valid; the first capture SHALL occur on the first clk edge after rst deasserts.
REQ-023 out SHALL remain a valid sum during reset.

Configuration
REQ-024 Macro ADDER_FLAGS_EN: when defined, carry_q, ovf_q, zero_q and neg_q SHALL be computed per REQ-015 to REQ-017; when undefined they SHALL be tied to constant 0 with ports retained, and sum_q, out_valid and out SHALL be unaffected.

Structure
REQ-025 Shared package adder_pkg SHALL hold the default WIDTH constant and a flags struct/typedef (carry, ovf, zero, neg).
REQ-026 Flag derivation SHALL live in one sub-module, adder_flags, which is combinational and takes the sum, carry and operand MSBs as inputs.

Verification
REQ-027 a=0, b=0 -> out=0; then a=1 -> out=1; then b=1 -> out=2; a=20, b=6 -> out=26, with each checked 10 time units after the change and no clock needed.
REQ-028 a=10, b=0xFD (-3), in_valid pulse -> out=7 immediately; next edge gives sum_q=7, carry_q=1, ovf_q=0, out_valid=1 for one cycle.
REQ-029 a=2, b=0xFB (-5) -> out=0xFD (-3); after capture, neg_q=1, carry_q=0, zero_q=0.
REQ-030 a=0x7F, b=0x01 captured -> sum_q=0x80, ovf_q=1; a=0x80, b=0x80 captured -> sum_q=0, carry_q=1, ovf_q=1, zero_q=1.
REQ-031 rst asserted between clock edges while in_valid=1 -> registered outputs clear at once, and no capture occurs until the first edge after release.
REQ-032 Build without ADDER_FLAGS_EN, with the REQ-030 stimulus -> sum_q correct, all four flags 0.
